bullet_pool: RTL and testbench
==============================

# bullet_pool

Parametrised projectile engine for the playfield: manages up to N_BULLETS independent bullets, each with its own column, row and in-flight flag. Launches on a shoot request from the ship position, advances all airborne bullets one row per movement tick, and retires them on hit or on reaching the top row. Sits between the input/ship logic and the collision and render stages; replaces the single-bullet engine.

## Interface
- N_BULLETS, 4: number of bullet slots (1..16).
- X_W, 5: column width in bits.
- Y_W, 4: row width in bits.
- START_Y, 12: row loaded on launch; must be less than 2^Y_W−1.
- TICK_CYCLES, 50000: clock cycles per movement tick (≥2).
- COOLDOWN_TICKS, 2: ticks between accepted launches (used only with BULLET_COOLDOWN_EN).

Ports:
- clk_36MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  game running; low freezes motion and blocks launches.
- shoot  in  1  launch request, level sampled every cycle.
- ship_x  in  X_W  ship column at launch.
- hit  in  N_BULLETS  per-slot collision report from the collision stage.
- bullet_flying  out  N_BULLETS  slot in flight.
- bullet_x  out  N_BULLETS*X_W  packed columns, slot i at [i*X_W +: X_W].
- bullet_y  out  N_BULLETS*Y_W  packed rows, slot i at [i*Y_W +: Y_W].
- shot_ack  out  1  one-cycle pulse: launch accepted.
- shot_drop  out  1  one-cycle pulse: launch refused (pool full or cooling down).
- pool_full  out  1  all slots flying (combinational from bullet_flying).

## Operation
- Reset (async assert, sync release): bullet_flying=0, every bullet_x=0, every bullet_y=IDLE_Y (all ones), shot_ack=0, shot_drop=0, tick counter=0, cooldown=0.
- Idle slot always holds x=0, y=IDLE_Y.
- Launch: shoot=1 and enable=1 and a free slot exists (and cooldown expired, if compiled) → lowest-index free slot gets flying=1, x=ship_x, y=START_Y; shot_ack=1 next cycle. One launch per cycle max. Held shoot launches on consecutive cycles until full.
- Refused: shoot=1, enable=1, no eligible launch → shot_drop=1. shoot with enable=0 → neither pulse.
- Free-slot search uses registered flags: a slot retiring this cycle is not reusable until the next.
- Retire (per slot, evaluated regardless of enable): flying and (hit[i]=1 or y=0) → slot returns to idle. hit on an idle slot ignored.
- Move: on tick, every flying slot not retiring decrements y by one. Slot launched this cycle is not moved.
- Per-slot priority: retire > move > hold. Bullet reaching y=0 on a tick retires on the following cycle.

## Timing
- Tick counter runs 0..TICK_CYCLES−1 only while enable=1; tick is asserted in the cycle the counter equals TICK_CYCLES−1, then wraps to 0. enable low holds the count.
- All outputs registered except pool_full. Launch latency: 1 cycle shoot→flying. Hit latency: 1 cycle hit→idle.
- Bullet launched at START_Y with no hit reaches y=0 after START_Y ticks, idle one cycle later.
- Reset mid-flight clears all slots immediately; no pending pulses survive.

## Configuration
- BULLET_COOLDOWN_EN defined: after each accepted launch, a cooldown counter loads COOLDOWN_TICKS and decrements on each tick; launches refused (shot_drop) while non-zero. Counter freezes with enable=0; cleared by reset.
- Undefined: no cooldown logic; launches limited only by slot availability; COOLDOWN_TICKS ignored.

## Structure
- Package bullet_pkg: IDLE_Y derivation from Y_W, slot index width function (clog2 of N_BULLETS), default parameter constants.
- Sub-module tick_gen: enable-gated free-running divider producing the single-cycle tick, parameter TICK_CYCLES. Priority encoder for free slot stays inline.

## Test plan
- Reset: N_BULLETS=3, assert reset mid-flight → all flying=0, x=0, y=15 same cycle, no pulses.
- Launch/fill: ship_x=7, shoot held 4 cycles → slots 0,1,2 launch at y=12 with x=7, shot_ack ×3, then shot_drop, pool_full=1.
- Flight: TICK_CYCLES=4, one bullet at 12 → y=0 after 48 cycles, idle at cycle 49, no hit.
- Hit/reuse: hit[1] while slots 0..2 full and shoot=1 → slot 1 idle next cycle, shot_drop that cycle, relaunch into slot 1 cycle after.
- Freeze: enable=0 for 20 cycles mid-flight → y and tick count unchanged, hit still retires, shoot gives no pulses.
- Cooldown (BULLET_COOLDOWN_EN, COOLDOWN_TICKS=2): shoot held → second launch accepted only after 2 ticks, shot_drop pulses in between.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared constants and helpers for the bullet pool: parameter defaults,
// idle-row derivation and slot-index width.
package bullet_pkg;

    localparam int DEF_N_BULLETS      = 4;
    localparam int DEF_X_W            = 5;
    localparam int DEF_Y_W            = 4;
    localparam int DEF_START_Y        = 12;
    localparam int DEF_TICK_CYCLES    = 50000;
    localparam int DEF_COOLDOWN_TICKS = 2;

    // Row value parked in an idle slot: all ones for the given row width.
    function automatic int unsigned idle_y(input int unsigned y_w);
        return (32'd1 << y_w) - 32'd1;
    endfunction

    // Bits needed to index n items, never less than one.
    function automatic int unsigned slot_idx_w(input int unsigned n);
        return (n <= 1) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Enable-gated divider: emits a one-cycle tick every TICK_CYCLES enabled
// cycles; the count holds while enable is low.
module tick_gen
    import bullet_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/bullet_pool.sv
// Multi-slot projectile engine: launch, per-tick climb and retirement.
// Optional launch cooldown compiled in with BULLET_COOLDOWN_EN.
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int N_BULLETS      = DEF_N_BULLETS,
    parameter int X_W            = DEF_X_W,
    parameter int Y_W            = DEF_Y_W,
    parameter int START_Y        = DEF_START_Y,
    parameter int TICK_CYCLES    = DEF_TICK_CYCLES,
    parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS
) (
    input  logic                     clk_36MHz,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     shoot,
    input  logic [X_W-1:0]           ship_x,
    input  logic [N_BULLETS-1:0]     hit,
    output logic [N_BULLETS-1:0]     bullet_flying,
    output logic [N_BULLETS*X_W-1:0] bullet_x,
    output logic [N_BULLETS*Y_W-1:0] bullet_y,
    output logic                     shot_ack,
    output logic                     shot_drop,
    output logic                     pool_full
);

    localparam int IDX_W = slot_idx_w(N_BULLETS);
    localparam logic [Y_W-1:0] IDLE_Y  = Y_W'(idle_y(Y_W));
    localparam logic [Y_W-1:0] LAUNCH_Y = Y_W'(START_Y);

    logic                 tick;
    logic [N_BULLETS-1:0] flying_vec;
    logic [IDX_W-1:0]     free_idx;
    logic                 any_free;
    logic                 cool_ok;
    logic                 launch;
    logic                 refuse;
    logic                 shot_ack_q;
    logic                 shot_drop_q;

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk_i   (clk_36MHz),
        .rst_i   (reset),
        .enable_i(enable),
        .tick_o  (tick)
    );

    // Lowest-index free slot, judged on registered flags only.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (!flying_vec[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

    assign launch = shoot && enable && any_free && cool_ok;
    assign refuse = shoot && enable && !launch;

`ifdef BULLET_COOLDOWN_EN
    localparam int CD_W = slot_idx_w(COOLDOWN_TICKS + 1);

    logic [CD_W-1:0] cd_q, cd_d;

    always_comb begin
        cd_d = cd_q;
        if (launch) begin
            cd_d = CD_W'(COOLDOWN_TICKS);
        end else if (tick && (cd_q != '0)) begin
            cd_d = cd_q - CD_W'(1);
        end
    end

    always_ff @(posedge clk_36MHz or posedge reset) begin
        if (reset) begin
            cd_q <= '0;
        end else begin
            cd_q <= cd_d;
        end
    end

    assign cool_ok = (cd_q == '0);
`else
    logic unused_cooldown;
    assign unused_cooldown = ^32'(COOLDOWN_TICKS);
    assign cool_ok = 1'b1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_BULLETS; gi++) begin : g_slot
            logic           fly_q, fly_d;
            logic [X_W-1:0] x_q, x_d;
            logic [Y_W-1:0] y_q, y_d;
            logic           retire;

            assign retire = fly_q && (hit[gi] || (y_q == '0));

            // Retire beats move beats hold; a launch only ever targets an idle slot.
            always_comb begin
                fly_d = fly_q;
                x_d   = x_q;
                y_d   = y_q;
                if (retire) begin
                    fly_d = 1'b0;
                    x_d   = '0;
                    y_d   = IDLE_Y;
                end else if (fly_q) begin
                    if (tick) begin
                        y_d = y_q - Y_W'(1);
                    end
                end else if (launch && (free_idx == IDX_W'(gi))) begin
                    fly_d = 1'b1;
                    x_d   = ship_x;
                    y_d   = LAUNCH_Y;
                end
            end

            always_ff @(posedge clk_36MHz or posedge reset) begin
                if (reset) begin
                    fly_q <= 1'b0;
                    x_q   <= '0;
                    y_q   <= IDLE_Y;
                end else begin
                    fly_q <= fly_d;
                    x_q   <= x_d;
                    y_q   <= y_d;
                end
            end

            assign flying_vec[gi]              = fly_q;
            assign bullet_flying[gi]           = fly_q;
            assign bullet_x[gi*X_W +: X_W]     = x_q;
            assign bullet_y[gi*Y_W +: Y_W]     = y_q;
        end
    endgenerate

    always_ff @(posedge clk_36MHz or posedge reset) begin
        if (reset) begin
            shot_ack_q  <= 1'b0;
            shot_drop_q <= 1'b0;
        end else begin
            shot_ack_q  <= launch;
            shot_drop_q <= refuse;
        end
    end

    assign shot_ack  = shot_ack_q;
    assign shot_drop = shot_drop_q;
    assign pool_full = &flying_vec;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool (3 slots, 4-cycle tick); the cooldown
// sequence replaces the main one when BULLET_COOLDOWN_EN is defined.
module tb_bullet_pool;

    logic        clk_36MHz = 1'b0;
    logic        reset;
    logic        enable;
    logic        shoot;
    logic [4:0]  ship_x;
    logic [2:0]  hit;
    logic [2:0]  bullet_flying;
    logic [14:0] bullet_x;
    logic [11:0] bullet_y;
    logic        shot_ack;
    logic        shot_drop;
    logic        pool_full;

    int checks   = 0;
    int failures = 0;
    int count_v;
    logic pulses;

    bullet_pool #(
        .N_BULLETS     (3),
        .X_W           (5),
        .Y_W           (4),
        .START_Y       (12),
        .TICK_CYCLES   (4),
        .COOLDOWN_TICKS(2)
    ) dut (
        .clk_36MHz    (clk_36MHz),
        .reset        (reset),
        .enable       (enable),
        .shoot        (shoot),
        .ship_x       (ship_x),
        .hit          (hit),
        .bullet_flying(bullet_flying),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .shot_ack     (shot_ack),
        .shot_drop    (shot_drop),
        .pool_full    (pool_full)
    );

    always #5 clk_36MHz = ~clk_36MHz;

    task automatic step();
        @(posedge clk_36MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        shoot  = 1'b0;
        ship_x = 5'd0;
        hit    = 3'b000;
        step();
        step();
        check("rst_flying", 32'(bullet_flying), 32'h0);
        check("rst_x",      32'(bullet_x),      32'h0);
        check("rst_y",      32'(bullet_y),      32'hFFF);
        check("rst_ack",    32'(shot_ack),      32'h0);
        check("rst_drop",   32'(shot_drop),     32'h0);
        check("rst_full",   32'(pool_full),     32'h0);
        reset = 1'b0;

`ifdef BULLET_COOLDOWN_EN
        enable = 1'b1;
        shoot  = 1'b1;
        ship_x = 5'd4;
        step();
        check("cd_ack1",  32'(shot_ack),      32'h1);
        check("cd_fly1",  32'(bullet_flying), 32'h1);
        step();
        check("cd_drop",  32'(shot_drop),     32'h1);
        count_v = 0;
        repeat (6) begin
            step();
            count_v += int'(shot_drop);
        end
        check("cd_drops",  32'(count_v),       32'd6);
        check("cd_fly_hold", 32'(bullet_flying), 32'h1);
        step();
        check("cd_ack2",  32'(shot_ack),      32'h1);
        check("cd_fly2",  32'(bullet_flying), 32'h3);
        check("cd_x1",    32'(bullet_x[9:5]), 32'd4);
`else
        // Fill: held shoot claims slots 0,1,2 then gets refused.
        enable = 1'b1;
        shoot  = 1'b1;
        ship_x = 5'd7;
        step();
        check("fill_fly1",  32'(bullet_flying),  32'h1);
        check("fill_x0",    32'(bullet_x[4:0]),  32'd7);
        check("fill_y0",    32'(bullet_y[3:0]),  32'd12);
        check("fill_ack1",  32'(shot_ack),       32'h1);
        check("fill_drop1", 32'(shot_drop),      32'h0);
        step();
        check("fill_fly2",  32'(bullet_flying),  32'h3);
        check("fill_x1",    32'(bullet_x[9:5]),  32'd7);
        check("fill_ack2",  32'(shot_ack),       32'h1);
        step();
        check("fill_fly3",  32'(bullet_flying),  32'h7);
        check("fill_full",  32'(pool_full),      32'h1);
        check("fill_y2",    32'(bullet_y[11:8]), 32'd12);
        step();
        check("full_drop",  32'(shot_drop),      32'h1);
        check("full_ack",   32'(shot_ack),       32'h0);
        check("tick_y0",    32'(bullet_y[3:0]),  32'd11);
        check("tick_y2",    32'(bullet_y[11:8]), 32'd11);

        // Hit on slot 1 while full: freed slot is reusable only a cycle later.
        hit = 3'b010;
        step();
        check("hit_fly",    32'(bullet_flying),  32'h5);
        check("hit_x1",     32'(bullet_x[9:5]),  32'd0);
        check("hit_y1",     32'(bullet_y[7:4]),  32'd15);
        check("hit_drop",   32'(shot_drop),      32'h1);
        check("hit_ack",    32'(shot_ack),       32'h0);
        hit    = 3'b000;
        ship_x = 5'd9;
        step();
        check("reuse_fly",  32'(bullet_flying),  32'h7);
        check("reuse_x1",   32'(bullet_x[9:5]),  32'd9);
        check("reuse_y1",   32'(bullet_y[7:4]),  32'd12);
        check("reuse_ack",  32'(shot_ack),       32'h1);
        shoot = 1'b0;
        step();
        step();
        check("move_y0",    32'(bullet_y[3:0]),  32'd10);
        check("move_y1",    32'(bullet_y[7:4]),  32'd11);
        check("move_y2",    32'(bullet_y[11:8]), 32'd10);

        // Freeze for 21 cycles: hit still retires, no motion, no pulses.
        enable = 1'b0;
        shoot  = 1'b1;
        hit    = 3'b001;
        step();
        check("frz_hit_fly", 32'(bullet_flying), 32'h6);
        check("frz_ack",     32'(shot_ack),      32'h0);
        check("frz_drop",    32'(shot_drop),     32'h0);
        hit    = 3'b000;
        pulses = 1'b0;
        repeat (20) begin
            step();
            pulses = pulses | shot_ack | shot_drop;
        end
        check("frz_pulses", 32'(pulses),          32'h0);
        check("frz_y1",     32'(bullet_y[7:4]),   32'd11);
        check("frz_y2",     32'(bullet_y[11:8]),  32'd10);
        enable = 1'b1;
        shoot  = 1'b0;
        step();
        step();
        step();
        check("thaw_hold_y1", 32'(bullet_y[7:4]),  32'd11);
        step();
        check("thaw_y1",      32'(bullet_y[7:4]),  32'd10);
        check("thaw_y2",      32'(bullet_y[11:8]), 32'd9);

        // Asynchronous reset right after a launch clears state and the ack.
        shoot  = 1'b1;
        ship_x = 5'd3;
        step();
        check("pre_rst_ack", 32'(shot_ack),      32'h1);
        check("pre_rst_x0",  32'(bullet_x[4:0]), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_fly",  32'(bullet_flying), 32'h0);
        check("arst_x",    32'(bullet_x),      32'h0);
        check("arst_y",    32'(bullet_y),      32'hFFF);
        check("arst_ack",  32'(shot_ack),      32'h0);
        check("arst_full", 32'(pool_full),     32'h0);

        // Full flight: launch at 12, y=0 after 48 cycles, idle at cycle 49.
        ship_x = 5'd5;
        step();
        reset = 1'b0;
        step();
        check("fl_fly",   32'(bullet_flying), 32'h1);
        check("fl_y_l",   32'(bullet_y[3:0]), 32'd12);
        check("fl_x",     32'(bullet_x[4:0]), 32'd5);
        shoot = 1'b0;
        repeat (23) step();
        check("fl_y_mid", 32'(bullet_y[3:0]), 32'd6);
        repeat (24) step();
        check("fl_y_top", 32'(bullet_y[3:0]), 32'd0);
        check("fl_fly48", 32'(bullet_flying), 32'h1);
        step();
        check("fl_idle",  32'(bullet_flying), 32'h0);
        check("fl_y_idl", 32'(bullet_y[3:0]), 32'd15);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
